i2s_rx_tdm: RTL and testbench

I2S_RX_TDM -- requirements
Module: i2s_rx_tdm

---
 rtl/i2s_rx_tdm.sv | 238 +++++++++++++++++++++++
 tb/tb_i2s_rx_tdm.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_tdm.sv
// i2s_rx_tdm: I2S / left-justified TDM serial audio receiver.
//
// sclk, lrclk and sdi are oversampled on clk, which must run at least 4x sclk.
// The falling edge of lrclk is the frame sync. Each channel slot is SLOT_W bit
// clocks wide and carries DW data bits, MSB first. A completed frame is
// presented on data with a valid/ready handshake.
//
// Optional feature macro: I2S_RX_TDM_SYNC_EN
//   defined   - sclk, lrclk and sdi each pass through a 2-flop synchronizer
//               before edge detection (adds 2 clk of latency).
//   undefined - the inputs must already be synchronous to clk.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous reset, active-high
//   sclk       serial bit clock (sampled)
//   lrclk      frame sync / word select (sampled)
//   sdi        serial data, MSB first (sampled)
//   data       frame samples, channel k at [k*DW +: DW]
//   valid      data holds a complete, unconsumed frame
//   ready      consumer accepts data when valid && ready
//   overrun    1-cycle pulse: a completed frame was dropped
//   frame_err  1-cycle pulse: frame sync arrived mid-frame
module i2s_rx_tdm #(
    parameter int unsigned DW     = 24,
    parameter int unsigned SLOT_W = 32,
    parameter int unsigned NCH    = 2,
    parameter int unsigned LJ     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              lrclk,
    input  logic              sdi,
    output logic [NCH*DW-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              overrun,
    output logic              frame_err
);

    localparam int unsigned FW   = NCH * DW;
    localparam int unsigned PMAX = NCH * SLOT_W + 1;
    localparam int unsigned PW   = $clog2(PMAX + 1);
    localparam int unsigned BW   = $clog2(SLOT_W);
    localparam int unsigned SW   = $clog2(NCH + 1);

    localparam logic [PW-1:0] P_SAT       = PW'(PMAX);
    localparam logic [BW-1:0] B_DW        = BW'(DW);
    localparam logic [BW-1:0] B_LAST_DATA = BW'(DW - 1);
    localparam logic [BW-1:0] B_LAST      = BW'(SLOT_W - 1);
    localparam logic [SW-1:0] S_NCH       = SW'(NCH);
    localparam logic [SW-1:0] S_LAST      = SW'(NCH - 1);

    logic sclk_in;
    logic lrclk_in;
    logic sdi_in;

`ifdef I2S_RX_TDM_SYNC_EN
    logic [1:0] sclk_sync_q,  sclk_sync_d;
    logic [1:0] lrclk_sync_q, lrclk_sync_d;
    logic [1:0] sdi_sync_q,   sdi_sync_d;

    // Two-flop synchronizers; lrclk idles high so reset it to 1.
    always_comb begin
        sclk_sync_d  = {sclk_sync_q[0], sclk};
        lrclk_sync_d = {lrclk_sync_q[0], lrclk};
        sdi_sync_d   = {sdi_sync_q[0], sdi};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q  <= 2'b00;
            lrclk_sync_q <= 2'b11;
            sdi_sync_q   <= 2'b00;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            lrclk_sync_q <= lrclk_sync_d;
            sdi_sync_q   <= sdi_sync_d;
        end
    end

    assign sclk_in  = sclk_sync_q[1];
    assign lrclk_in = lrclk_sync_q[1];
    assign sdi_in   = sdi_sync_q[1];
`else
    assign sclk_in  = sclk;
    assign lrclk_in = lrclk;
    assign sdi_in   = sdi;
`endif

    logic          sclk_q,      sclk_d;
    logic          lrclk_q,     lrclk_d;
    logic          locked_q,    locked_d;
    logic [PW-1:0] p_q,         p_d;
    logic [BW-1:0] bit_q,       bit_d;
    logic [SW-1:0] slot_q,      slot_d;
    logic [SW-1:0] wr_cnt_q,    wr_cnt_d;
    logic [DW-1:0] shift_q,     shift_d;
    logic [FW-1:0] buf_q,       buf_d;
    logic          done_q,      done_d;
    logic [FW-1:0] data_q,      data_d;
    logic          valid_q,     valid_d;
    logic          overrun_q,   overrun_d;
    logic          frame_err_q, frame_err_d;

    logic          sclk_rise;
    logic          fsync;
    logic [PW-1:0] cur_p;
    logic [BW-1:0] cur_bit;
    logic [SW-1:0] cur_slot;
    logic [SW-1:0] cur_wr;
    logic [DW-1:0] cur_shift;
    logic [DW-1:0] word;

    // Capture datapath and output handshake.
    always_comb begin
        sclk_d      = sclk_in;
        lrclk_d     = lrclk_in;
        locked_d    = locked_q;
        p_d         = p_q;
        bit_d       = bit_q;
        slot_d      = slot_q;
        wr_cnt_d    = wr_cnt_q;
        shift_d     = shift_q;
        buf_d       = buf_q;
        done_d      = 1'b0;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;

        sclk_rise = sclk_in & ~sclk_q;
        fsync     = ~lrclk_in & lrclk_q;

        cur_p     = p_q;
        cur_bit   = bit_q;
        cur_slot  = slot_q;
        cur_wr    = wr_cnt_q;
        cur_shift = shift_q;

        // Frame sync restarts the frame before any same-cycle sclk rise.
        if (fsync) begin
            frame_err_d = (wr_cnt_q != '0) && (wr_cnt_q < S_NCH);
            locked_d    = 1'b1;
            cur_p       = '0;
            cur_bit     = '0;
            cur_slot    = '0;
            cur_wr      = '0;
            cur_shift   = '0;
            p_d         = '0;
            bit_d       = '0;
            slot_d      = '0;
            wr_cnt_d    = '0;
            shift_d     = '0;
        end

        word = {cur_shift[DW-2:0], sdi_in};

        if (sclk_rise && locked_d) begin
            // In I2S mode position 0 is the delay bit; slots past NCH-1 are ignored.
            if (((LJ != 0) || (cur_p != '0)) && (cur_slot < S_NCH)) begin
                if (cur_bit < B_DW) begin
                    shift_d = word;
                end
                if (cur_bit == B_LAST_DATA) begin
                    for (int unsigned k = 0; k < NCH; k++) begin
                        if (cur_slot == SW'(k)) begin
                            buf_d[k*DW +: DW] = word;
                        end
                    end
                    wr_cnt_d = cur_wr + SW'(1);
                    done_d   = (cur_slot == S_LAST);
                end
                if (cur_bit == B_LAST) begin
                    bit_d  = '0;
                    slot_d = cur_slot + SW'(1);
                end else begin
                    bit_d  = cur_bit + BW'(1);
                end
            end
            p_d = (cur_p == P_SAT) ? cur_p : cur_p + PW'(1);
        end

        // A completed frame either loads (consumer free or accepting) or is dropped.
        if (done_q) begin
            if (!valid_q || ready) begin
                data_d  = buf_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers; lrclk_q resets high so release never looks like a sync.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q      <= 1'b0;
            lrclk_q     <= 1'b1;
            locked_q    <= 1'b0;
            p_q         <= '0;
            bit_q       <= '0;
            slot_q      <= '0;
            wr_cnt_q    <= '0;
            shift_q     <= '0;
            buf_q       <= '0;
            done_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_q      <= sclk_d;
            lrclk_q     <= lrclk_d;
            locked_q    <= locked_d;
            p_q         <= p_d;
            bit_q       <= bit_d;
            slot_q      <= slot_d;
            wr_cnt_q    <= wr_cnt_d;
            shift_q     <= shift_d;
            buf_q       <= buf_d;
            done_q      <= done_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_rx_tdm.sv
// Testbench for i2s_rx_tdm: a stereo I2S instance (DW=24, SLOT_W=32, NCH=2,
// LJ=0) and an 8-channel left-justified TDM instance (DW=16, SLOT_W=32,
// NCH=8, LJ=1) share the serial inputs; each scenario checks the instance
// whose framing it drives.
module tb_i2s_rx_tdm;

`ifdef I2S_RX_TDM_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk;
    logic         lrclk;
    logic         sdi;
    logic         ready;

    logic [47:0]  data_a;
    logic         valid_a, overrun_a, ferr_a;
    logic [127:0] data_b;
    logic         valid_b, overrun_b, ferr_b;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int rise_cyc = 0;
    int cap_cyc = 0;

    int vcnt_a = 0, ocnt_a = 0, fcnt_a = 0, first_v_a = 0;
    int vcnt_b = 0;
    logic [47:0]  last_a = '0;
    logic [127:0] last_b = '0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    i2s_rx_tdm #(.DW(24), .SLOT_W(32), .NCH(2), .LJ(0)) u_dut_a (
        .clk(clk), .rst(rst), .sclk(sclk), .lrclk(lrclk), .sdi(sdi),
        .data(data_a), .valid(valid_a), .ready(ready),
        .overrun(overrun_a), .frame_err(ferr_a)
    );

    i2s_rx_tdm #(.DW(16), .SLOT_W(32), .NCH(8), .LJ(1)) u_dut_b (
        .clk(clk), .rst(rst), .sclk(sclk), .lrclk(lrclk), .sdi(sdi),
        .data(data_b), .valid(valid_b), .ready(ready),
        .overrun(overrun_b), .frame_err(ferr_b)
    );

    // Output monitor, sampled 1 time unit after each rising clk edge.
    always @(posedge clk) begin
        #1;
        if (valid_a === 1'b1) begin
            if (vcnt_a == 0) first_v_a = cyc;
            vcnt_a++;
            last_a = data_a;
        end
        if (overrun_a === 1'b1) ocnt_a++;
        if (ferr_a === 1'b1) fcnt_a++;
        if (valid_b === 1'b1) begin
            vcnt_b++;
            last_b = data_b;
        end
    end

    task automatic clear_counts();
        vcnt_a = 0; ocnt_a = 0; fcnt_a = 0; first_v_a = 0; vcnt_b = 0;
    endtask

    // One serial bit: 4 clk with sclk low, then 4 clk with sclk high.
    task automatic send_bit(input logic lr, input logic d);
        @(negedge clk);
        sclk = 1'b0; lrclk = lr; sdi = d;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        rise_cyc = cyc;
        repeat (3) @(negedge clk);
    endtask

    // I2S frame bits [first, nbits): delay bit, then left/right 24-bit words in
    // 32-bit slots. Ignored positions (delay, padding, extra slots) carry 1s.
    task automatic send_i2s(input logic [23:0] l, input logic [23:0] r,
                            input int first, input int nbits, input int lr_hi);
        int e;
        int b;
        logic d;
        logic [23:0] w;
        for (int i = first; i < nbits; i++) begin
            d = 1'b1;
            if (i > 0) begin
                e = i - 1;
                b = e % 32;
                if (e < 64 && b < 24) begin
                    w = (e < 32) ? l : r;
                    d = w[23 - b];
                end
            end
            send_bit(i >= lr_hi, d);
            if (i == 56) cap_cyc = rise_cyc;
        end
    endtask

    // Left-justified 8-slot TDM frame, slot k = 0x1111*k, padding bits 1.
    task automatic send_lj();
        int s;
        int b;
        logic d;
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            s = i / 32;
            b = i % 32;
            w = 16'(32'h1111 * s);
            d = (b < 16) ? w[15 - b] : 1'b1;
            send_bit(i >= 32, d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk = 1'b0; lrclk = 1'b1; sdi = 1'b0; ready = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (data_a !== 48'h0) begin n_fail++; $display("FAIL reset_data_a: got %h expected 0", data_a); end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a: got %b expected 0", valid_a); end
        n_checks++; if (overrun_a !== 1'b0) begin n_fail++; $display("FAIL reset_overrun_a: got %b expected 0", overrun_a); end
        n_checks++; if (ferr_a !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err_a: got %b expected 0", ferr_a); end
        n_checks++; if (data_b !== 128'h0) begin n_fail++; $display("FAIL reset_data_b: got %h expected 0", data_b); end
        n_checks++; if (valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b: got %b expected 0", valid_b); end
        n_checks++; if (overrun_b !== 1'b0) begin n_fail++; $display("FAIL reset_overrun_b: got %b expected 0", overrun_b); end
        n_checks++; if (ferr_b !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err_b: got %b expected 0", ferr_b); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_stereo();
        ready = 1'b1;
        clear_counts();
        send_i2s(24'hA5A5A5, 24'h5A5A5A, 0, 64, 32);
        repeat (4) @(negedge clk);
        n_checks++; if (vcnt_a != 1) begin n_fail++; $display("FAIL stereo_valid_cycles: got %0d expected 1", vcnt_a); end
        n_checks++; if (last_a !== 48'h5A5A5A_A5A5A5) begin n_fail++; $display("FAIL stereo_data: got %h expected 5a5a5aa5a5a5", last_a); end
        n_checks++; if (first_v_a != cap_cyc + 2 + SYNC_LAT) begin n_fail++; $display("FAIL stereo_latency: valid at cycle %0d expected %0d", first_v_a, cap_cyc + 2 + SYNC_LAT); end
        n_checks++; if (ocnt_a != 0) begin n_fail++; $display("FAIL stereo_overrun: got %0d pulses expected 0", ocnt_a); end
        n_checks++; if (fcnt_a != 0) begin n_fail++; $display("FAIL stereo_frame_err: got %0d pulses expected 0", fcnt_a); end
    endtask

    // 100-bit frame: slots beyond NCH-1 carry 1s and must not disturb data.
    task automatic test_long_frame();
        clear_counts();
        send_i2s(24'h123456, 24'h654321, 0, 100, 32);
        n_checks++; if (vcnt_a != 1) begin n_fail++; $display("FAIL long_valid_cycles: got %0d expected 1", vcnt_a); end
        n_checks++; if (last_a !== 48'h654321_123456) begin n_fail++; $display("FAIL long_data: got %h expected 654321123456", last_a); end
    endtask

    task automatic test_tdm_lj();
        logic [15:0] exp_w;
        clear_counts();
        send_lj();
        send_lj();
        repeat (4) @(negedge clk);
        n_checks++; if (vcnt_b != 2) begin n_fail++; $display("FAIL tdm_valid_count: got %0d expected 2", vcnt_b); end
        for (int k = 0; k < 8; k++) begin
            exp_w = 16'(32'h1111 * k);
            n_checks++;
            if (last_b[k*16 +: 16] !== exp_w) begin
                n_fail++;
                $display("FAIL tdm_slot%0d: got %h expected %h", k, last_b[k*16 +: 16], exp_w);
            end
        end
    endtask

    task automatic test_overrun();
        @(negedge clk);
        ready = 1'b0;
        clear_counts();
        send_i2s(24'h000001, 24'h000002, 0, 64, 32);
        send_i2s(24'h000003, 24'h000004, 0, 64, 32);
        n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL overrun_valid_held: got %b expected 1", valid_a); end
        n_checks++; if (data_a !== 48'h000002_000001) begin n_fail++; $display("FAIL overrun_data_kept: got %h expected 000002000001", data_a); end
        n_checks++; if (ocnt_a != 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d expected 1", ocnt_a); end
        ready = 1'b1;
        @(negedge clk);
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL overrun_ready_clears: got %b expected 0", valid_a); end
    endtask

    task automatic test_frame_err();
        ready = 1'b1;
        clear_counts();
        // No word completed before the next sync: silent restart.
        send_i2s(24'hFFFFFF, 24'hFFFFFF, 0, 10, 5);
        // Left word completed only.
        send_i2s(24'hFFFFFF, 24'hFFFFFF, 0, 40, 32);
        n_checks++; if (fcnt_a != 0) begin n_fail++; $display("FAIL ferr_empty_sync: got %0d pulses expected 0", fcnt_a); end
        send_i2s(24'h0F0F0F, 24'hF0F0F0, 0, 64, 32);
        n_checks++; if (fcnt_a != 1) begin n_fail++; $display("FAIL ferr_partial_sync: got %0d pulses expected 1", fcnt_a); end
        n_checks++; if (vcnt_a != 1) begin n_fail++; $display("FAIL ferr_valid_count: got %0d expected 1", vcnt_a); end
        n_checks++; if (last_a !== 48'hF0F0F0_0F0F0F) begin n_fail++; $display("FAIL ferr_next_frame: got %h expected f0f0f00f0f0f", last_a); end
    endtask

    task automatic test_reset_mid_frame();
        logic [23:0] r;
        r = 24'h222222;
        send_i2s(24'h111111, r, 0, 43, 32);
        // Right-channel bit 10 (frame position 43): reset with its sclk rise.
        @(negedge clk);
        sclk = 1'b0; lrclk = 1'b1; sdi = r[13];
        repeat (4) @(negedge clk);
        sclk = 1'b1; rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (data_a !== 48'h0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", data_a); end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", valid_a); end
        n_checks++; if (overrun_a !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b expected 0", overrun_a); end
        n_checks++; if (ferr_a !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_err: got %b expected 0", ferr_a); end
        sclk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_counts();
        send_i2s(24'h111111, r, 44, 64, 32);
        n_checks++; if (vcnt_a != 0) begin n_fail++; $display("FAIL midrst_no_valid: got %0d valid cycles expected 0", vcnt_a); end
        send_i2s(24'hABCDEF, 24'h13579B, 0, 64, 32);
        n_checks++; if (vcnt_a != 1) begin n_fail++; $display("FAIL midrst_valid_after_sync: got %0d expected 1", vcnt_a); end
        n_checks++; if (last_a !== 48'h13579B_ABCDEF) begin n_fail++; $display("FAIL midrst_data_after_sync: got %h expected 13579babcdef", last_a); end
        n_checks++; if (fcnt_a != 0) begin n_fail++; $display("FAIL midrst_frame_err_count: got %0d expected 0", fcnt_a); end
    endtask

    initial begin
        test_reset();
        test_stereo();
        test_long_frame();
        test_tdm_lj();
        test_overrun();
        test_frame_err();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
